seg_display_scan: RTL and testbench

- Time-multiplexed scan controller for a 4-digit common-segment 7-segment display.
- Holds a 16-bit value as four hex nibbles and presents one nibble at a time on o_binary_num, which feeds the registered 4-bit-to-7-segment decoder directly downstream.
- Drives one-hot digit enables, with a blanking gap on every digit change that covers the decoder's 1-cycle register latency and prevents ghosting.
- Double-buffers the displayed value so a frame never shows a mix of old and new nibbles.

---
 rtl/seg_display_scan.sv | 114 +++++++++++
 tb/tb_seg_display_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Four-digit 7-segment scan controller with a double-buffered value,
// a blanking gap on every digit change and leading-zero suppression.
module seg_display_scan #(
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic        i_enable,
  input  logic        i_lz_suppress,
  output logic [3:0]  o_binary_num,
  output logic [3:0]  o_digit_en,
  output logic [1:0]  o_digit_idx,
  output logic        o_frame_done
);

  localparam int CW = (CLKS_PER_DIGIT > 2) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CLKS - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   shadow, active, active_n;
  logic          pending, pending_n;
  logic          apply;
  logic [15:0]   shifted;
  logic [3:0]    en_q;
  logic [3:0]    sup;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    apply   = 1'b0;
    if (!i_enable) begin
      state_n = BLANK;
      cnt_n   = '0;
      apply   = 1'b1;
    end else if (state == BLANK) begin
      cnt_n = cnt + 1'b1;
      if (cnt == BLAST)
        state_n = SHOW;
    end else if (cnt == LAST) begin
      cnt_n   = '0;
      idx_n   = idx + 2'd1;
      state_n = BLANK;
      apply   = (idx == 2'd3);
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  // A load on the boundary cycle itself bypasses the shadow register.
  always_comb begin
    active_n  = active;
    pending_n = pending;
    if (apply) begin
      pending_n = 1'b0;
      if (i_load)
        active_n = i_value;
      else if (pending)
        active_n = shadow;
    end else if (i_load) begin
      pending_n = 1'b1;
    end
  end

  assign shifted = active_n >> {idx_n, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= 2'd0;
      shadow       <= 16'h0;
      active       <= 16'h0;
      pending      <= 1'b0;
      o_binary_num <= 4'h0;
      en_q         <= 4'h0;
      o_frame_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      active  <= active_n;
      pending <= pending_n;
      if (i_load)
        shadow <= i_value;
      if (state_n == BLANK)
        o_binary_num <= shifted[3:0];
      en_q <= (state_n == SHOW) ? (4'b0001 << idx_n) : 4'b0000;
      o_frame_done <= i_enable && (state_n == SHOW) &&
                      (idx_n == 2'd3) && (cnt_n == LAST);
    end
  end

  // Digit k is dark when it and every higher nibble are zero.
  assign sup[0] = 1'b0;
  assign sup[1] = (active[15:4] == 12'h0);
  assign sup[2] = (active[15:8] == 8'h0);
  assign sup[3] = (active[15:12] == 4'h0);

  assign o_digit_en  = en_q & ~(sup & {4{i_lz_suppress}});
  assign o_digit_idx = idx;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan: frame table plus
// hand-written enable, reset and boundary-load sequences.
module tb_seg_display_scan;

  localparam int CPD = 8;
  localparam int BL  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_value;
  logic        i_load;
  logic        i_enable;
  logic        i_lz_suppress;
  logic [3:0]  o_binary_num;
  logic [3:0]  o_digit_en;
  logic [1:0]  o_digit_idx;
  logic        o_frame_done;

  seg_display_scan #(
    .CLKS_PER_DIGIT(CPD),
    .BLANK_CLKS(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_value(i_value),
    .i_load(i_load),
    .i_enable(i_enable),
    .i_lz_suppress(i_lz_suppress),
    .o_binary_num(o_binary_num),
    .o_digit_en(o_digit_en),
    .o_digit_idx(o_digit_idx),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bn;
    logic [3:0] en;
    logic [1:0] idx;
    logic       fd;
    string      tag;
  } exp_t;

  // One row per frame: shown value, per-digit enables (nibble k = digit k),
  // suppress setting, and up to two loads placed at (digit, slot position).
  typedef struct {
    logic [15:0] nibs;
    logic [15:0] ens;
    logic        lz;
    int          a_dig;
    int          a_pos;
    logic [15:0] a_val;
    int          b_dig;
    int          b_pos;
    logic [15:0] b_val;
  } frame_t;

  exp_t   sb[$];
  frame_t ft[6];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic step(input logic [3:0] bn, input logic [3:0] en,
                      input logic [1:0] idx, input logic fd,
                      input string tag);
    exp_t e;
    exp_t g;
    e.bn  = bn;
    e.en  = en;
    e.idx = idx;
    e.fd  = fd;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sb.pop_front();
    n_cmp++;
    if (o_binary_num !== g.bn || o_digit_en !== g.en ||
        o_digit_idx !== g.idx || o_frame_done !== g.fd) begin
      n_bad++;
      $display("FAIL %s: got bn=%h en=%b idx=%0d fd=%b, want bn=%h en=%b idx=%0d fd=%b",
               g.tag, o_binary_num, o_digit_en, o_digit_idx, o_frame_done,
               g.bn, g.en, g.idx, g.fd);
    end
    i_load = 1'b0;
  endtask

  task automatic slot(input logic [3:0] nib, input logic [3:0] en,
                      input logic [1:0] idx, input logic last,
                      input int start, input int ld_pos,
                      input logic [15:0] ld_val, input string tag);
    for (int p = start; p < CPD; p++) begin
      if (p == ld_pos) begin
        i_load  = 1'b1;
        i_value = ld_val;
      end
      step(nib, (p < BL) ? 4'b0000 : en, idx, last && (p == CPD - 1),
           $sformatf("%s p%0d", tag, p));
    end
  endtask

  task automatic run_frame(input int f, input int start0);
    frame_t     r;
    logic [3:0] nib;
    logic [3:0] en;
    int         lp;
    logic [15:0] lv;
    r = ft[f];
    i_lz_suppress = r.lz;
    for (int d = 0; d < 4; d++) begin
      nib = r.nibs[d*4 +: 4];
      en  = r.ens[d*4 +: 4];
      lp  = -1;
      lv  = 16'h0;
      if (r.a_dig == d) begin
        lp = r.a_pos;
        lv = r.a_val;
      end else if (r.b_dig == d) begin
        lp = r.b_pos;
        lv = r.b_val;
      end
      slot(nib, en, 2'(d), d == 3, (d == 0) ? start0 : 0, lp, lv,
           $sformatf("frame%0d d%0d", f, d));
    end
  endtask

  initial begin
    ft[0] = '{16'h1234, 16'h8421, 1'b0, 1,  3, 16'hABCD, -1, 0, 16'h0};
    ft[1] = '{16'hABCD, 16'h8421, 1'b0, 1,  3, 16'h5678,  3, 5, 16'h0F0F};
    ft[2] = '{16'h0F0F, 16'h8421, 1'b0, 2,  2, 16'h0050, -1, 0, 16'h0};
    ft[3] = '{16'h0050, 16'h0021, 1'b1, 0,  6, 16'h0000, -1, 0, 16'h0};
    ft[4] = '{16'h0000, 16'h0001, 1'b1, -1, 0, 16'h0,    -1, 0, 16'h0};
    ft[5] = '{16'h5555, 16'h8421, 1'b1, 0,  0, 16'h5555, -1, 0, 16'h0};

    rst           = 1'b1;
    i_enable      = 1'b0;
    i_load        = 1'b0;
    i_value       = 16'h0;
    i_lz_suppress = 1'b0;
    step(4'h0, 4'h0, 2'd0, 1'b0, "reset");

    rst     = 1'b0;
    i_load  = 1'b1;
    i_value = 16'h1234;
    step(4'h4, 4'h0, 2'd0, 1'b0, "load disabled");

    i_enable = 1'b1;
    run_frame(0, 1);
    for (int f = 1; f < 6; f++)
      run_frame(f, 0);

    // Drop enable in the SHOW part of digit 2, then resume there.
    slot(4'h5, 4'b0001, 2'd0, 1'b0, 0, -1, 16'h0, "en d0");
    slot(4'h5, 4'b0010, 2'd1, 1'b0, 0, -1, 16'h0, "en d1");
    for (int p = 0; p < 4; p++)
      step(4'h5, (p < BL) ? 4'b0000 : 4'b0100, 2'd2, 1'b0, "en d2 pre");
    i_enable = 1'b0;
    repeat (3) step(4'h5, 4'h0, 2'd2, 1'b0, "disabled");
    i_enable = 1'b1;
    slot(4'h5, 4'b0100, 2'd2, 1'b0, 1, -1, 16'h0, "reenable d2");
    slot(4'h5, 4'b1000, 2'd3, 1'b1, 0, -1, 16'h0, "reenable d3");

    // Reset part-way through digit 3.
    slot(4'h5, 4'b0001, 2'd0, 1'b0, 0, -1, 16'h0, "rst d0");
    slot(4'h5, 4'b0010, 2'd1, 1'b0, 0, -1, 16'h0, "rst d1");
    slot(4'h5, 4'b0100, 2'd2, 1'b0, 0, -1, 16'h0, "rst d2");
    for (int p = 0; p < 4; p++)
      step(4'h5, (p < BL) ? 4'b0000 : 4'b1000, 2'd3, 1'b0, "rst d3 pre");
    rst = 1'b1;
    step(4'h0, 4'h0, 2'd0, 1'b0, "rst mid");
    rst = 1'b0;
    slot(4'h0, 4'b0001, 2'd0, 1'b0, 1, -1, 16'h0, "post rst d0");
    slot(4'h0, 4'b0000, 2'd1, 1'b0, 0, -1, 16'h0, "post rst d1");
    slot(4'h0, 4'b0000, 2'd2, 1'b0, 0, -1, 16'h0, "post rst d2");
    slot(4'h0, 4'b0000, 2'd3, 1'b1, 0, -1, 16'h0, "post rst d3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
